reg_rename_file: RTL

REG_RENAME_FILE -- requirements
Module: reg_rename_file

---
 rtl/reg_rename_file.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/reg_rename_file.sv
// Architectural register file with rename state (busy/tag per register) and
// rename checkpoints; combinational operand read with commit and ROB bypass.
module reg_rename_file #(
    parameter int XLEN     = 32,
    parameter int REG_BIT  = 5,
    parameter int ROB_BIT  = 4,
    parameter int RD_PORTS = 2,
    parameter int CKPT_BIT = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush_in,
    input  logic                         commit_en,
    input  logic [REG_BIT-1:0]           commit_id,
    input  logic [XLEN-1:0]              commit_data,
    input  logic [ROB_BIT-1:0]           commit_tag,
    input  logic                         issue_en,
    input  logic [REG_BIT-1:0]           issue_id,
    input  logic [ROB_BIT-1:0]           issue_tag,
    input  logic                         ckpt_save,
    input  logic [CKPT_BIT-1:0]          ckpt_save_idx,
    input  logic                         ckpt_restore,
    input  logic [CKPT_BIT-1:0]          ckpt_restore_idx,
    input  logic [RD_PORTS*REG_BIT-1:0]  rd_id,
    output logic [RD_PORTS*XLEN-1:0]     rd_val,
    output logic [RD_PORTS-1:0]          rd_dep,
    output logic [RD_PORTS*ROB_BIT-1:0]  rd_tag,
    output logic [RD_PORTS*ROB_BIT-1:0]  rob_q_tag,
    input  logic [RD_PORTS-1:0]          rob_q_ready,
    input  logic [RD_PORTS*XLEN-1:0]     rob_q_value
);

    localparam int REG_NUM  = 1 << REG_BIT;
    localparam int CKPT_NUM = 1 << CKPT_BIT;

    logic [XLEN-1:0]    r_regs    [REG_NUM];
    logic [REG_NUM-1:0] r_busy;
    logic [ROB_BIT-1:0] r_tag     [REG_NUM];
    logic [REG_NUM-1:0] r_ck_busy [CKPT_NUM];
    logic [ROB_BIT-1:0] r_ck_tag  [CKPT_NUM][REG_NUM];

    logic [REG_NUM-1:0] w_busy_nxt;
    logic [ROB_BIT-1:0] w_tag_nxt     [REG_NUM];
    logic [REG_NUM-1:0] w_ck_busy_nxt [CKPT_NUM];
    logic [ROB_BIT-1:0] w_ck_tag_nxt  [CKPT_NUM][REG_NUM];

    logic w_commit;
    logic w_issue;

    assign w_commit = commit_en && (commit_id != '0);
    assign w_issue  = issue_en  && (issue_id  != '0);

    // Commit clears snapshots too, so a later restore cannot resurrect a
    // dependency whose producer has already retired.
    always_comb begin
        w_busy_nxt    = r_busy;
        w_tag_nxt     = r_tag;
        w_ck_busy_nxt = r_ck_busy;
        w_ck_tag_nxt  = r_ck_tag;
        if (w_commit) begin
            if (r_busy[commit_id] && (r_tag[commit_id] == commit_tag))
                w_busy_nxt[commit_id] = 1'b0;
            for (int k = 0; k < CKPT_NUM; k++) begin
                if (r_ck_tag[k][commit_id] == commit_tag)
                    w_ck_busy_nxt[k][commit_id] = 1'b0;
            end
        end
        if (flush_in) begin
            w_busy_nxt = '0;
            for (int i = 0; i < REG_NUM; i++) w_tag_nxt[i] = '0;
            for (int k = 0; k < CKPT_NUM; k++) begin
                w_ck_busy_nxt[k] = '0;
                for (int i = 0; i < REG_NUM; i++) w_ck_tag_nxt[k][i] = '0;
            end
        end else if (ckpt_restore) begin
            w_busy_nxt = w_ck_busy_nxt[ckpt_restore_idx];
            w_tag_nxt  = r_ck_tag[ckpt_restore_idx];
        end else begin
            // Issue after commit: a same-register issue overrides the clear.
            if (w_issue) begin
                w_busy_nxt[issue_id] = 1'b1;
                w_tag_nxt[issue_id]  = issue_tag;
            end
            if (ckpt_save) begin
                w_ck_busy_nxt[ckpt_save_idx] = w_busy_nxt;
                w_ck_tag_nxt[ckpt_save_idx]  = w_tag_nxt;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_busy <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
                r_tag[i]  <= '0;
            end
            for (int k = 0; k < CKPT_NUM; k++) begin
                r_ck_busy[k] <= '0;
                for (int i = 0; i < REG_NUM; i++) r_ck_tag[k][i] <= '0;
            end
        end else if (rdy_in) begin
            r_busy    <= w_busy_nxt;
            r_tag     <= w_tag_nxt;
            r_ck_busy <= w_ck_busy_nxt;
            r_ck_tag  <= w_ck_tag_nxt;
            if (w_commit) r_regs[commit_id] <= commit_data;
        end
    end

    for (genvar gp = 0; gp < RD_PORTS; gp++) begin : g_rd
        logic [REG_BIT-1:0] w_idx;
        logic [XLEN-1:0]    w_val;
        logic               w_dep;
        logic [ROB_BIT-1:0] w_dtag;

        assign w_idx = rd_id[gp*REG_BIT +: REG_BIT];

        always_comb begin
            w_val  = '0;
            w_dep  = 1'b0;
            w_dtag = '0;
            if (w_idx == '0) begin
                w_val = '0;
            end else if (!r_busy[w_idx]) begin
                w_val = r_regs[w_idx];
            end else if (commit_en && (commit_id == w_idx) && (commit_tag == r_tag[w_idx])) begin
                w_val = commit_data;
            end else if (rob_q_ready[gp]) begin
                w_val = rob_q_value[gp*XLEN +: XLEN];
            end else begin
                w_dep  = 1'b1;
                w_dtag = r_tag[w_idx];
            end
        end

        assign rd_val[gp*XLEN +: XLEN]         = w_val;
        assign rd_dep[gp]                      = w_dep;
        assign rd_tag[gp*ROB_BIT +: ROB_BIT]    = w_dtag;
        assign rob_q_tag[gp*ROB_BIT +: ROB_BIT] = r_tag[w_idx];
    end

endmodule
